lane_merge_sched: RTL
=====================

LANE_MERGE_SCHED -- requirements
Module: lane_merge_sched

Interface
REQ-001 SHALL have parameter SKEW_MAX, default 8, meaning the number of consecutive skew-stall cycles before a lane flush (legal range 2..255).
REQ-002 SHALL have port clk_2f  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port valid_0  input  1  lane 0 word present.
REQ-005 SHALL have port lane_0  input  32  lane 0 data word.
REQ-006 SHALL have port ready_0  output  1  lane 0 buffer can accept a word.
REQ-007 SHALL have port valid_1  input  1  lane 1 word present.
REQ-008 SHALL have port lane_1  input  32  lane 1 data word.
REQ-009 SHALL have port ready_1  output  1  lane 1 buffer can accept a word.
REQ-010 SHALL have port data_out  output  32  merged word, registered.
REQ-011 SHALL have port valid_out  output  1  data_out holds a valid word.
REQ-012 SHALL have port ready_out  input  1  downstream accepts data_out.
REQ-013 SHALL have port skew_err  output  1  one-cycle pulse on a skew flush.

Function
REQ-014 SHALL accept a lane word on each rising edge where valid_x and ready_x are both 1, writing it into that lane's 2-entry FIFO.
REQ-015 SHALL drive ready_x = 1 when lane x's FIFO holds fewer than 2 words and the FSM is not in FLUSH.
REQ-016 SHALL run the FSM states EXP0 (expect lane 0), EXP1 (expect lane 1), and FLUSH.
REQ-017 SHALL define "output slot free" as valid_out == 0, or valid_out == 1 with ready_out == 1 at the same edge.
REQ-018 SHALL, in EXP0 with FIFO0 non-empty and the output slot free, load the FIFO0 head into data_out, set valid_out, pop FIFO0, and go to EXP1; EXP1 SHALL behave symmetrically with FIFO1, returning to EXP0.
REQ-019 SHALL give a word written at edge N, into an empty FIFO of the expected lane with the output slot free, a latency of one cycle: it appears on data_out after edge N+1.
REQ-020 SHALL allow a push and a pop on the same FIFO at the same edge; the FIFO count SHALL then be unchanged and ordering preserved.
REQ-021 SHALL hold data_out and valid_out stable while valid_out == 1 and ready_out == 0.
REQ-022 SHALL clear valid_out at an edge where ready_out == 1 and no new word is loaded.
REQ-023 SHALL increment an 8-bit skew counter each cycle the expected FIFO is empty while the other FIFO holds 2 words.
REQ-024 SHALL clear the skew counter in any other cycle and on every state transition.
REQ-025 SHALL go to FLUSH when the skew counter reaches SKEW_MAX.
REQ-026 SHALL, in FLUSH (exactly one cycle), empty both FIFOs, pulse skew_err = 1, keep any pending data_out/valid_out word, and then go to EXP0.
REQ-027 SHALL ignore lane input during FLUSH, since ready_0 = ready_1 = 0.

Reset
REQ-028 SHALL, while reset = 1, asynchronously force: FSM = EXP0, both FIFOs empty, skew counter = 0, data_out = 32'h00000000, valid_out = 0, skew_err = 0, ready_0 = ready_1 = 0.
REQ-029 SHALL, after reset deassertion, drive ready_0/ready_1 = 1 from the first rising edge onward.
REQ-030 SHALL abandon all buffered words when reset asserts mid-operation, with no output word emitted for them.

Configuration
REQ-031 SHALL, when macro LANE_MERGE_STATS_EN is defined, add output word_count (16 bits) and output flush_count (8 bits).
REQ-032 SHALL, with LANE_MERGE_STATS_EN, increment word_count on each data_out handshake (valid_out & ready_out), wrapping 16'hFFFF to 0.
REQ-033 SHALL, with LANE_MERGE_STATS_EN, increment flush_count on each FLUSH entry, saturating at 8'hFF.
REQ-034 SHALL, with LANE_MERGE_STATS_EN, reset both counters to 0.
REQ-035 SHALL, without LANE_MERGE_STATS_EN, omit these ports and their logic entirely, leaving all other behaviour identical.

Verification
REQ-036 SHALL cover in-order merge: lane_0 = FFFFFFFF, then lane_1 = EEEEEEEE, then lane_0 = DDDDDDDD, then lane_1 = CCCCCCCC, ready_out = 1 -> data_out sequence FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC, one word per cycle.
REQ-037 SHALL cover early lane: lane_1 = 00000004 two cycles before lane_0 = 00000003 -> data_out 00000003 then 00000004, no skew_err.
REQ-038 SHALL cover backpressure: ready_out = 0 for 5 cycles with both FIFOs full -> data_out stable, ready_0 = ready_1 = 0, no word lost after release.
REQ-039 SHALL cover skew flush: fill FIFO1 with 2 words while lane 0 stays idle, SKEW_MAX = 8 -> skew_err pulses at the 8th stall cycle, FIFOs empty, FSM = EXP0.
REQ-040 SHALL cover mid-stream reset: reset = 1 while FIFO0 holds 1 word and valid_out = 1 -> valid_out = 0 and data_out = 0 immediately, without waiting for a clock edge.
REQ-041 SHALL cover stats (LANE_MERGE_STATS_EN): 4 words accepted plus 1 flush -> word_count = 4, flush_count = 1.

Source files
------------

// File: rtl/lane_merge_sched.sv
// lane_merge_sched: merges two 32-bit lanes into one registered output stream,
// strictly alternating lane 0, lane 1, lane 0, ... Each lane has a 2-entry
// FIFO. If the expected lane stays empty while the other lane's FIFO is full
// for SKEW_MAX consecutive cycles, both FIFOs are flushed and skew_err pulses.
// Optional build macro LANE_MERGE_STATS_EN adds word_count and flush_count.
module lane_merge_sched #(
    parameter int SKEW_MAX = 8
) (
    input  logic        clk_2f,
    input  logic        reset,
    input  logic        valid_0,
    input  logic [31:0] lane_0,
    output logic        ready_0,
    input  logic        valid_1,
    input  logic [31:0] lane_1,
    output logic        ready_1,
    output logic [31:0] data_out,
    output logic        valid_out,
    input  logic        ready_out,
`ifdef LANE_MERGE_STATS_EN
    output logic [15:0] word_count,
    output logic [7:0]  flush_count,
`endif
    output logic        skew_err
);

    typedef enum logic [1:0] {
        ST_EXP0  = 2'd0,
        ST_EXP1  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Counter value at which one more stall cycle triggers the flush
    localparam logic [7:0] SKEW_LAST = 8'(SKEW_MAX - 1);

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  skew_cnt_r;
    logic [7:0]  skew_cnt_next_s;
    logic [31:0] mem_r [2][2];
    logic [1:0]  cnt_r [2];
    logic [1:0]  cnt_next_s [2];
    logic        ready_r [2];
    logic        ready_next_s [2];
    logic [31:0] lane_data_s [2];
    logic        push_s [2];
    logic        pop_s [2];
    logic        exp_s;
    logic        stall_s;
    logic        slot_free_s;
    logic        load_s;
    logic [31:0] load_data_s;
    logic [31:0] data_out_r;
    logic        valid_out_r;
    logic        skew_err_r;

    assign ready_0   = ready_r[0];
    assign ready_1   = ready_r[1];
    assign data_out  = data_out_r;
    assign valid_out = valid_out_r;
    assign skew_err  = skew_err_r;

    // Next-state, FIFO pop/push decisions and skew counting
    always_comb begin
        lane_data_s[0]  = lane_0;
        lane_data_s[1]  = lane_1;
        push_s[0]       = valid_0 & ready_r[0];
        push_s[1]       = valid_1 & ready_r[1];
        pop_s[0]        = 1'b0;
        pop_s[1]        = 1'b0;
        exp_s           = 1'b0;
        stall_s         = 1'b0;
        load_s          = 1'b0;
        load_data_s     = 32'd0;
        state_next_s    = state_r;
        skew_cnt_next_s = 8'd0;
        slot_free_s     = ~valid_out_r | ready_out;

        case (state_r)
            ST_EXP0, ST_EXP1: begin
                exp_s   = (state_r == ST_EXP1);
                stall_s = (cnt_r[exp_s] == 2'd0) && (cnt_r[~exp_s] == 2'd2);
                if ((cnt_r[exp_s] != 2'd0) && slot_free_s) begin
                    pop_s[exp_s] = 1'b1;
                    load_s       = 1'b1;
                    load_data_s  = mem_r[exp_s][0];
                    state_next_s = exp_s ? ST_EXP0 : ST_EXP1;
                end else if (stall_s) begin
                    if (skew_cnt_r == SKEW_LAST) begin
                        state_next_s = ST_FLUSH;
                    end else begin
                        skew_cnt_next_s = skew_cnt_r + 8'd1;
                    end
                end else begin
                    skew_cnt_next_s = 8'd0;
                end
            end
            ST_FLUSH: begin
                state_next_s = ST_EXP0;
            end
            default: begin
                state_next_s = ST_EXP0;
            end
        endcase

        for (int i = 0; i < 2; i++) begin
            if (state_r == ST_FLUSH) begin
                cnt_next_s[i] = 2'd0;
            end else begin
                cnt_next_s[i] = cnt_r[i] + {1'b0, push_s[i]} - {1'b0, pop_s[i]};
            end
            ready_next_s[i] = (cnt_next_s[i] != 2'd2) && (state_next_s != ST_FLUSH);
        end
    end

    // FSM, skew counter, lane ready flags and the registered output word
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state_r     <= ST_EXP0;
            skew_cnt_r  <= 8'd0;
            ready_r[0]  <= 1'b0;
            ready_r[1]  <= 1'b0;
            data_out_r  <= 32'h0000_0000;
            valid_out_r <= 1'b0;
            skew_err_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            skew_cnt_r <= skew_cnt_next_s;
            ready_r[0] <= ready_next_s[0];
            ready_r[1] <= ready_next_s[1];
            skew_err_r <= (state_next_s == ST_FLUSH);
            if (load_s) begin
                data_out_r  <= load_data_s;
                valid_out_r <= 1'b1;
            end else if (ready_out) begin
                valid_out_r <= 1'b0;
            end else begin
                valid_out_r <= valid_out_r;
            end
        end
    end

    // Lane FIFO storage: entry 0 is always the head, pops shift entry 1 down
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_r[i][0] <= 32'd0;
                mem_r[i][1] <= 32'd0;
                cnt_r[i]    <= 2'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push_s[i] && pop_s[i]) begin
                    mem_r[i][0] <= (cnt_r[i] == 2'd2) ? mem_r[i][1] : lane_data_s[i];
                    mem_r[i][1] <= lane_data_s[i];
                end else if (pop_s[i]) begin
                    mem_r[i][0] <= mem_r[i][1];
                end else if (push_s[i]) begin
                    mem_r[i][cnt_r[i][0]] <= lane_data_s[i];
                end
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

`ifdef LANE_MERGE_STATS_EN
    logic [15:0] word_count_r;
    logic [7:0]  flush_count_r;

    assign word_count  = word_count_r;
    assign flush_count = flush_count_r;

    // Output handshake counter (wrapping) and flush-entry counter (saturating)
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            word_count_r  <= 16'd0;
            flush_count_r <= 8'd0;
        end else begin
            if (valid_out_r && ready_out) begin
                word_count_r <= word_count_r + 16'd1;
            end
            if ((state_next_s == ST_FLUSH) && (state_r != ST_FLUSH) &&
                (flush_count_r != 8'hFF)) begin
                flush_count_r <= flush_count_r + 8'd1;
            end
        end
    end
`endif

endmodule
